// File: rtl/mdclcg_pkg.sv
// Shared types and constants for the dual-CLCG bit packer.
// Holds the packer FSM states, default geometry and monobit health-check limits.
package mdclcg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDiscard,
    StCollect
  } pk_state_e;

  localparam int unsigned DefWordW   = 32;
  localparam int unsigned DefDepth   = 4;
  localparam int unsigned DefDiscard = 8;

  // A word passes the monobit check when its popcount lies within [lo, hi].
  function automatic int unsigned pop_lo(input int unsigned word_w);
    return word_w / 4;
  endfunction

  function automatic int unsigned pop_hi(input int unsigned word_w);
    return (3 * word_w) / 4;
  endfunction

endpackage

// File: rtl/mdclcg_word_fifo.sv
// Synchronous word FIFO with flush, occupancy level and drop indication.
// The output holds the last popped word while the FIFO is empty.
module mdclcg_word_fifo #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_rdata,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_empty,
  output logic              o_drop
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [WORD_W-1:0] r_last;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_empty   = (r_level == '0);
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);
  assign o_drop    = i_push & ~i_flush & w_full & ~w_do_pop;
  assign o_level   = r_level;
  assign o_rdata   = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      r_level <= r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/mdclcg_bit_packer.sv
// Packs the dual-CLCG 1-bit stream into WORD_W-bit words behind a valid/ready FIFO.
// Optional monobit health check on every completed word: define MDCLCG_MONOBIT_EN.
module mdclcg_bit_packer
  import mdclcg_pkg::*;
#(
  parameter int unsigned WORD_W  = DefWordW,
  parameter int unsigned DEPTH   = DefDepth,
  parameter int unsigned DISCARD = DefDiscard,
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              overflow
`ifdef MDCLCG_MONOBIT_EN
  ,
  output logic              health_err
`endif
);

  localparam int unsigned CW = $clog2(WORD_W);
  localparam int unsigned DW = (DISCARD > 1) ? $clog2(DISCARD) : 1;

  pk_state_e         r_state, w_state_d;
  logic              r_armed, w_armed_d;
  logic [WORD_W-2:0] r_sreg, w_sreg_d;
  logic [CW-1:0]     r_bcnt, w_bcnt_d;
  logic [DW-1:0]     r_dcnt, w_dcnt_d;
  logic              r_overflow;
  logic              w_push;
  logic              w_drop;
  logic              w_empty;
  logic [WORD_W-1:0] w_word;

  assign w_word = {r_sreg, bit_in};

  // r_armed remembers that start was seen, so IDLE is left only after a start release.
  always_comb begin
    w_state_d = r_state;
    w_armed_d = r_armed;
    w_sreg_d  = r_sreg;
    w_bcnt_d  = r_bcnt;
    w_dcnt_d  = r_dcnt;
    w_push    = 1'b0;
    if (start) begin
      w_state_d = StIdle;
      w_armed_d = 1'b1;
      w_sreg_d  = '0;
      w_bcnt_d  = '0;
      w_dcnt_d  = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_armed) begin
            w_armed_d = 1'b0;
            w_state_d = (DISCARD > 0) ? StDiscard : StCollect;
          end
        end
        StDiscard: begin
          if (bit_en) begin
            if (r_dcnt == DW'(DISCARD - 1)) begin
              w_dcnt_d  = '0;
              w_state_d = StCollect;
            end else begin
              w_dcnt_d = r_dcnt + DW'(1);
            end
          end
        end
        StCollect: begin
          if (bit_en) begin
            w_sreg_d = w_word[WORD_W-2:0];
            if (r_bcnt == CW'(WORD_W - 1)) begin
              w_push   = 1'b1;
              w_bcnt_d = '0;
            end else begin
              w_bcnt_d = r_bcnt + CW'(1);
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_armed    <= 1'b0;
      r_sreg     <= '0;
      r_bcnt     <= '0;
      r_dcnt     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_armed <= w_armed_d;
      r_sreg  <= w_sreg_d;
      r_bcnt  <= w_bcnt_d;
      r_dcnt  <= w_dcnt_d;
      if (start)       r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

  mdclcg_word_fifo #(
    .WORD_W(WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_flush(start),
    .i_push (w_push),
    .i_wdata(w_word),
    .i_pop  (out_ready),
    .o_rdata(out_data),
    .o_level(level),
    .o_empty(w_empty),
    .o_drop (w_drop)
  );

  assign out_valid = ~w_empty;
  assign overflow  = r_overflow;

`ifdef MDCLCG_MONOBIT_EN
  int unsigned w_ones;
  logic        r_health;

  always_comb begin
    w_ones = int unsigned'($countones(w_word));
  end

  // Dropped words are still checked: the push request, not the FIFO accept, qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_health <= 1'b0;
    end else if (start) begin
      r_health <= 1'b0;
    end else if (w_push && (w_ones < pop_lo(WORD_W) || w_ones > pop_hi(WORD_W))) begin
      r_health <= 1'b1;
    end
  end

  assign health_err = r_health;
`endif

endmodule
